microgreen_bnn_scheduler: RTL and testbench
===========================================

// Module: microgreen_bnn_scheduler
// PURPOSE
//   Shares one microgreen BNN inference core among NUM_REQ sensor requesters.
//   Arbitrates round-robin, issues the winner's 16-bit feature word (four 4-bit
//   features: height, colour, width, stem) to the core, waits for completion and
//   returns class plus hidden activations tagged with the requester ID.
//   Sits between the sensor front-ends and the BNN core.
// PARAMETERS
//   NUM_REQ     4   number of requesters (2..8)
//   FEAT_W      16  feature word width: {stem,width,colour,height}
//   TIMEOUT_CYC 15  max cycles in WAIT before a timeout response (1..255)
// PORTS
//   clk          in   1              clock, rising edge
//   rst          in   1              asynchronous reset, active-high
//   req_valid    in   NUM_REQ        per-requester request valid
//   req_feat     in   NUM_REQ*FEAT_W requester i feature word in bits [i*FEAT_W +: FEAT_W]
//   req_ready    out  NUM_REQ        one-hot grant; a request is accepted when valid&ready
//   core_start   out  1              one-cycle pulse that starts an inference
//   core_feat    out  FEAT_W         feature word, held stable from start until done or timeout
//   core_done    in   1              one-cycle pulse from the core; result valid in the same cycle
//   core_class   in   3              class result from the core
//   core_hidden  in   4              hidden-layer activations from the core
//   rsp_valid    out  1              response valid
//   rsp_ready    in   1              response consumer ready
//   rsp_id       out  3              requester index of the response
//   rsp_class    out  3              class (3'b111 on timeout)
//   rsp_hidden   out  4              hidden activations (4'b0000 on timeout)
//   rsp_err      out  1              1 = core timed out
//   busy         out  1              state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr_ptr 0; timeout counter 0.
//   FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   - IDLE: if any req_valid, grant the first valid index at or after rr_ptr
//     (cyclic search). req_ready is combinational, one-hot, to the winner in IDLE
//     only. On acceptance, latch the feature word and ID; rr_ptr <= winner+1 mod
//     NUM_REQ; go to ISSUE. With no valid request, stay in IDLE and rr_ptr is unchanged.
//   - ISSUE: core_start=1 for exactly this cycle; clear the counter; go to WAIT.
//   - WAIT: the counter increments each cycle. If core_done is seen, latch class and
//     hidden, rsp_err=0, go to RESP. Otherwise, when the counter reaches TIMEOUT_CYC,
//     rsp_class=3'b111, rsp_hidden=0, rsp_err=1, go to RESP. If core_done arrives in
//     the same cycle as the timeout, core_done wins.
//   - RESP: rsp_valid=1 with payload held stable until rsp_ready. On valid&ready,
//     go to IDLE; rsp_valid drops the next cycle.
//   - Minimum latency, request accept -> rsp_valid: 3 cycles (core_done in the first
//     WAIT cycle).
//   - core_done outside WAIT is ignored.
//   - A requester dropping req_valid while not granted has no effect.
//   - Reset mid-operation aborts the inference with no response; the core is not
//     re-started.
//   - At most one request is outstanding (no queue); req_ready=0 for all requesters
//     outside IDLE.
// CONFIGURATION
//   MICROGREEN_SCHED_STATS_EN defined: adds output stat_count [15:0] (completed
//     non-error inferences, saturating at 16'hFFFF) and stat_timeouts [7:0]
//     (saturating). Both increment on the RESP handshake and reset to 0.
//   Undefined: those ports and their counters do not exist.
// TESTING
//   1) Single request: req_valid=4'b0001, feat=16'h8F0F, core_done 2 cycles after
//      start with class 1, hidden 4'b1010 -> one core_start pulse, core_feat=16'h8F0F;
//      rsp id=0, class=1, hidden=4'b1010, err=0.
//   2) Round-robin: req_valid=4'b1111 held, rsp_ready=1, core answers immediately ->
//      grant order 0,1,2,3,0; no requester starves.
//   3) Timeout: core never asserts core_done -> rsp_valid exactly TIMEOUT_CYC cycles
//      after entering WAIT; class=3'b111, hidden=0, err=1.
//   4) Backpressure: rsp_ready=0 for 5 cycles -> payload stable, req_ready=0, no new
//      core_start; handshake on cycle 6 returns to IDLE.
//   5) Collision: core_done in the same cycle as the timeout -> err=0, core class
//      reported. Stray core_done in IDLE -> ignored.
//   6) Reset asserted in WAIT -> all outputs 0 immediately, rr_ptr=0, no response;
//      with STATS_EN, counters read 0 afterwards.

Source files
------------

// File: rtl/microgreen_bnn_scheduler.sv
// Round-robin scheduler sharing one microgreen BNN inference core among NUM_REQ requesters.
// Optional build macro MICROGREEN_SCHED_STATS_EN adds saturating completion/timeout counters.
module microgreen_bnn_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int FEAT_W      = 16,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*FEAT_W-1:0] req_feat,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      core_start,
   output logic [FEAT_W-1:0]         core_feat,
   input  logic                      core_done,
   input  logic [2:0]                core_class,
   input  logic [3:0]                core_hidden,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [2:0]                rsp_id,
   output logic [2:0]                rsp_class,
   output logic [3:0]                rsp_hidden,
   output logic                      rsp_err,
`ifdef MICROGREEN_SCHED_STATS_EN
   output logic [15:0]               stat_count,
   output logic [7:0]                stat_timeouts,
`endif
   output logic                      busy
);

   // Handshakes: a request transfers on req_valid[i] & req_ready[i]; a response
   // transfers on rsp_valid & rsp_ready, with the payload held stable until then.
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
   localparam logic [2:0] LAST_IDX     = 3'(NUM_REQ - 1);

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  rr_ptr;
   logic [2:0]  ptr_nxt;
   logic [2:0]  win_idx;
   logic        win_found;
   logic [3:0]  cand;
   logic [7:0]  valid_ext;
   logic [7:0]  grant_ext;
   logic [7:0]  wait_cnt;
   logic        timed_out;

   assign valid_ext = 8'(req_valid);

   // Cyclic search starting at rr_ptr; first valid requester wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 4'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = 4'(rr_ptr) + 4'(k);
         if (cand >= 4'(NUM_REQ)) begin
            cand = cand - 4'(NUM_REQ);
         end
         if (!win_found && valid_ext[cand[2:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[2:0];
         end
      end
   end

   assign ptr_nxt = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;

   always_comb begin
      grant_ext = 8'd0;
      if (state == IDLE && win_found && !rst) begin
         grant_ext[win_idx] = 1'b1;
      end
   end

   assign req_ready  = grant_ext[NUM_REQ-1:0];
   assign core_start = (state == ISSUE);
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);
   assign timed_out  = (wait_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // core_done takes priority over a timeout landing in the same cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (core_done || timed_out) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr     <= 3'd0;
         wait_cnt   <= 8'd0;
         core_feat  <= '0;
         rsp_id     <= 3'd0;
         rsp_class  <= 3'd0;
         rsp_hidden <= 4'd0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  core_feat <= req_feat[int'(win_idx)*FEAT_W +: FEAT_W];
                  rsp_id    <= win_idx;
                  rr_ptr    <= ptr_nxt;
               end
            end
            ISSUE: begin
               wait_cnt <= 8'd0;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (core_done) begin
                  rsp_class  <= core_class;
                  rsp_hidden <= core_hidden;
                  rsp_err    <= 1'b0;
               end else if (timed_out) begin
                  rsp_class  <= 3'b111;
                  rsp_hidden <= 4'b0000;
                  rsp_err    <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef MICROGREEN_SCHED_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_count    <= 16'd0;
         stat_timeouts <= 8'd0;
      end else if (state == RESP && rsp_ready) begin
         if (rsp_err) begin
            if (stat_timeouts != 8'hFF) stat_timeouts <= stat_timeouts + 8'd1;
         end else begin
            if (stat_count != 16'hFFFF) stat_count <= stat_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_microgreen_bnn_scheduler.sv
// Table-driven plus randomized bench for microgreen_bnn_scheduler against a transaction-level model.
module tb_microgreen_bnn_scheduler;
   localparam int NUM_REQ     = 4;
   localparam int FEAT_W      = 16;
   localparam int TIMEOUT_CYC = 15;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*FEAT_W-1:0] req_feat;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      core_start;
   logic [FEAT_W-1:0]         core_feat;
   logic                      core_done;
   logic [2:0]                core_class;
   logic [3:0]                core_hidden;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [2:0]                rsp_id;
   logic [2:0]                rsp_class;
   logic [3:0]                rsp_hidden;
   logic                      rsp_err;
   logic                      busy;
`ifdef MICROGREEN_SCHED_STATS_EN
   logic [15:0]               stat_count;
   logic [7:0]                stat_timeouts;
   int                        model_cnt;
   int                        model_to;
`endif

   microgreen_bnn_scheduler #(
      .NUM_REQ(NUM_REQ), .FEAT_W(FEAT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_feat(req_feat), .req_ready(req_ready),
      .core_start(core_start), .core_feat(core_feat), .core_done(core_done),
      .core_class(core_class), .core_hidden(core_hidden), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_class(rsp_class), .rsp_hidden(rsp_hidden),
      .rsp_err(rsp_err),
`ifdef MICROGREEN_SCHED_STATS_EN
      .stat_count(stat_count), .stat_timeouts(stat_timeouts),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  mask;
      logic [15:0] base;
      int          delay;
      logic [2:0]  cls;
      logic [3:0]  hid;
      int          stall;
      int          exp_id;
      int          exp_err;
   } vec_t;

   vec_t tbl[10];
   int   errors = 0;
   int   checks = 0;
   int   model_ptr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input logic [3:0] mask);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (mask[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   task automatic check_stats();
`ifdef MICROGREEN_SCHED_STATS_EN
      chk("stat_count", stat_count, model_cnt);
      chk("stat_timeouts", stat_timeouts, model_to);
`endif
   endtask

   // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of a quiet IDLE cycle.
   task automatic run_txn(input logic [3:0] mask, input logic [15:0] base, input int delay,
                          input logic [2:0] cls, input logic [3:0] hid, input int stall,
                          input int tbl_id, input int tbl_err);
      int          exp_id;
      int          exp_wait;
      int          waited;
      int          starts;
      logic        exp_err;
      logic [2:0]  exp_cls;
      logic [3:0]  exp_hid;
      logic [15:0] exp_feat;
      exp_id   = (tbl_id >= 0) ? tbl_id : model_pick(mask);
      exp_err  = (tbl_err >= 0) ? tbl_err[0] : (delay >= TIMEOUT_CYC);
      exp_wait = (delay >= TIMEOUT_CYC) ? TIMEOUT_CYC : delay + 1;
      exp_cls  = exp_err ? 3'b111 : cls;
      exp_hid  = exp_err ? 4'b0000 : hid;
      for (int i = 0; i < NUM_REQ; i++) req_feat[i*FEAT_W +: FEAT_W] = base + 16'(i) * 16'h1111;
      exp_feat  = base + 16'(exp_id) * 16'h1111;
      req_valid = mask;
      rsp_ready = 1'b0;
      core_done = 1'b0;
      @(negedge clk);
      chk("grant", 32'(req_ready), 32'(1) << exp_id);
      chk("idle_busy", 32'(busy), 0);
      model_ptr = (exp_id + 1) % NUM_REQ;
      tick();
      @(negedge clk);
      chk("core_start", 32'(core_start), 1);
      chk("core_feat", 32'(core_feat), 32'(exp_feat));
      chk("issue_ready", 32'(req_ready), 0);
      tick();
      waited = 0;
      starts = 0;
      for (int w = 0; w < 300; w++) begin
         core_done   = (w == delay);
         core_class  = cls;
         core_hidden = hid;
         @(negedge clk);
         if (core_start || req_ready != 0) starts++;
         tick();
         core_done = 1'b0;
         waited++;
         if (rsp_valid) break;
      end
      chk("latency", waited, exp_wait);
      chk("wait_quiet", starts, 0);
      chk("feat_hold", 32'(core_feat), 32'(exp_feat));
      for (int s = 0; s <= stall; s++) begin
         rsp_ready = (s == stall);
         core_done = 1'b1;
         core_class = ~cls;
         @(negedge clk);
         chk("rsp_valid", 32'(rsp_valid), 1);
         chk("rsp_id", 32'(rsp_id), exp_id);
         chk("rsp_class", 32'(rsp_class), 32'(exp_cls));
         chk("rsp_hidden", 32'(rsp_hidden), 32'(exp_hid));
         chk("rsp_err", 32'(rsp_err), 32'(exp_err));
         chk("resp_no_grant", 32'(req_ready), 0);
         chk("resp_no_start", 32'(core_start), 0);
         tick();
      end
      rsp_ready = 1'b0;
      core_done = 1'b0;
      req_valid = '0;
`ifdef MICROGREEN_SCHED_STATS_EN
      if (exp_err) model_to++;
      else model_cnt++;
`endif
      @(negedge clk);
      chk("rsp_dropped", 32'(rsp_valid), 0);
      chk("back_idle", 32'(busy), 0);
      check_stats();
      tick();
   endtask

   initial begin
      // mask, base, delay, cls, hid, stall, exp_id, exp_err
      tbl[0] = '{4'b1111, 16'h1234, 0,   3'd2, 4'b0011, 0, 0, 0};
      tbl[1] = '{4'b1111, 16'h2345, 0,   3'd3, 4'b0101, 0, 1, 0};
      tbl[2] = '{4'b1111, 16'h3456, 0,   3'd4, 4'b1001, 0, 2, 0};
      tbl[3] = '{4'b1111, 16'h4567, 0,   3'd5, 4'b1100, 0, 3, 0};
      tbl[4] = '{4'b1111, 16'h5678, 0,   3'd6, 4'b0110, 0, 0, 0};
      tbl[5] = '{4'b0001, 16'h8F0F, 1,   3'd1, 4'b1010, 0, 0, 0};
      tbl[6] = '{4'b0100, 16'hA0A0, 255, 3'd2, 4'b1111, 0, 2, 1};
      tbl[7] = '{4'b1000, 16'hBEEF, 0,   3'd4, 4'b0001, 5, 3, 0};
      tbl[8] = '{4'b0010, 16'hC0DE, 14,  3'd5, 4'b0110, 0, 1, 0};
      tbl[9] = '{4'b0011, 16'h0F0F, 15,  3'd3, 4'b0111, 1, 0, 1};

`ifdef MICROGREEN_SCHED_STATS_EN
      model_cnt = 0;
      model_to  = 0;
`endif
      rst = 1'b1;
      req_valid = 4'b1111;
      req_feat = '0;
      core_done = 1'b0;
      core_class = 3'd0;
      core_hidden = 4'd0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_core_feat", 32'(core_feat), 0);
      check_stats();
      req_valid = '0;
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         run_txn(tbl[i].mask, tbl[i].base, tbl[i].delay, tbl[i].cls, tbl[i].hid,
                 tbl[i].stall, tbl[i].exp_id, tbl[i].exp_err);
      end

      // stray core_done while idle must not start anything
      core_done = 1'b1;
      core_class = 3'd6;
      @(negedge clk);
      chk("stray_busy0", 32'(busy), 0);
      tick();
      core_done = 1'b0;
      @(negedge clk);
      chk("stray_busy1", 32'(busy), 0);
      chk("stray_rsp", 32'(rsp_valid), 0);
      chk("stray_start", 32'(core_start), 0);
      tick();

      for (int n = 0; n < 40; n++) begin
         run_txn(4'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 18),
                 3'($urandom), 4'($urandom), $urandom_range(0, 3), -1, -1);
      end

      // reset asserted mid-WAIT aborts silently and clears the round-robin pointer
      req_valid = 4'b1111;
      tick();
      req_valid = 4'b1111;
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      chk("abort_ready", 32'(req_ready), 0);
      chk("abort_start", 32'(core_start), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rsp_valid", 32'(rsp_valid), 0);
      chk("abort_payload", {17'd0, rsp_id, rsp_class, rsp_hidden, rsp_err}, 0);
      chk("abort_core_feat", 32'(core_feat), 0);
`ifdef MICROGREEN_SCHED_STATS_EN
      model_cnt = 0;
      model_to  = 0;
`endif
      check_stats();
      req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_ptr = 0;
      begin
         int activity;
         activity = 0;
         for (int c = 0; c < 20; c++) begin
            tick();
            if (core_start || rsp_valid || busy) activity++;
         end
         chk("abort_no_response", activity, 0);
      end
      run_txn(4'b1111, 16'h5A5A, 2, 3'd3, 4'b1001, 0, 0, 0);
      run_txn(4'b1111, 16'h6B6B, 0, 3'd1, 4'b0010, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
